// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit with a req/ack data bus, byte-lane steering and load extension.
// Optional feature macro ADDR_EXC_EN: misaligned accesses raise exc_adel/exc_ades instead of issuing.
module mem_lsu #(
  parameter int ADDR_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] mem_wd_i,
  input  logic              mem_wreg_i,
  input  logic [31:0]       mem_wdata_i,
  input  logic [3:0]        mem_op_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_sdata_i,
  input  logic              mem_enhilo_i,
  input  logic [31:0]       mem_hi_i,
  input  logic [31:0]       mem_lo_i,
  output logic              stall_req,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [3:0]        dbus_be,
  output logic [31:0]       dbus_wdata,
  input  logic [31:0]       dbus_rdata,
  input  logic              dbus_ack,
  output logic [REG_AW-1:0] wb_wd,
  output logic              wb_wreg,
  output logic [31:0]       wb_wdata,
  output logic              wb_enhilo,
  output logic [31:0]       wb_hi,
  output logic [31:0]       wb_lo,
  output logic              exc_adel,
  output logic              exc_ades,
  output logic [ADDR_W-1:0] exc_badvaddr
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic {IDLE, BUSY} state_t;
  state_t r_state, w_nextState;

  logic              r_dbusReq, r_dbusWe;
  logic [ADDR_W-1:0] r_dbusAddr;
  logic [3:0]        r_dbusBe;
  logic [31:0]       r_dbusWdata;
  logic [REG_AW-1:0] r_wbWd;
  logic              r_wbWreg, r_wbEnhilo;
  logic [31:0]       r_wbWdata, r_wbHi, r_wbLo;

  logic        w_isLoad, w_isStore, w_isHalf, w_isWord, w_fault, w_isMem;
  logic [1:0]  w_lane;
  logic [3:0]  w_be;
  logic [31:0] w_busWdata, w_loadData;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_lane    = mem_addr_i[1:0];
  assign w_isLoad  = (mem_op_i >= OP_LB) && (mem_op_i <= OP_LW);
  assign w_isStore = (mem_op_i >= OP_SB) && (mem_op_i <= OP_SW);
  assign w_isHalf  = (mem_op_i == OP_LH) || (mem_op_i == OP_LHU) || (mem_op_i == OP_SH);
  assign w_isWord  = (mem_op_i == OP_LW) || (mem_op_i == OP_SW);

`ifdef ADDR_EXC_EN
  assign w_fault = (w_isHalf && mem_addr_i[0]) || (w_isWord && (w_lane != 2'b00));
`else
  assign w_fault = 1'b0;
`endif

  assign w_isMem = (w_isLoad || w_isStore) && !w_fault;

  // Halfword/word lanes ignore the low address bits, which forces alignment when faults are off.
  always_comb begin
    w_be       = 4'b1111;
    w_busWdata = mem_sdata_i;
    if (w_isHalf) begin
      w_be       = mem_addr_i[1] ? 4'b1100 : 4'b0011;
      w_busWdata = {2{mem_sdata_i[15:0]}};
    end else if (!w_isWord) begin
      w_be       = 4'b0001 << w_lane;
      w_busWdata = {4{mem_sdata_i[7:0]}};
    end
  end

  always_comb begin
    case (w_lane)
      2'd0:    w_byte = dbus_rdata[7:0];
      2'd1:    w_byte = dbus_rdata[15:8];
      2'd2:    w_byte = dbus_rdata[23:16];
      default: w_byte = dbus_rdata[31:24];
    endcase
    w_half = mem_addr_i[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
    case (mem_op_i)
      OP_LB:   w_loadData = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  w_loadData = {24'h000000, w_byte};
      OP_LH:   w_loadData = {{16{w_half[15]}}, w_half};
      OP_LHU:  w_loadData = {16'h0000, w_half};
      default: w_loadData = dbus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_isMem) w_nextState = BUSY;
      BUSY:    if (dbus_ack) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Stall drops combinationally in the ack cycle so upstream advances on the completing edge.
  always_comb begin
    stall_req = 1'b0;
    case (r_state)
      IDLE:    stall_req = w_isMem;
      BUSY:    stall_req = !dbus_ack;
      default: stall_req = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dbusReq   <= 1'b0;
      r_dbusWe    <= 1'b0;
      r_dbusAddr  <= '0;
      r_dbusBe    <= 4'b0000;
      r_dbusWdata <= 32'h0;
      r_wbWd      <= '0;
      r_wbWreg    <= 1'b0;
      r_wbWdata   <= 32'h0;
      r_wbEnhilo  <= 1'b0;
      r_wbHi      <= 32'h0;
      r_wbLo      <= 32'h0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_isMem) begin
            r_dbusReq   <= 1'b1;
            r_dbusWe    <= w_isStore;
            r_dbusAddr  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
            r_dbusBe    <= w_be;
            r_dbusWdata <= w_busWdata;
            r_wbWreg    <= 1'b0;
            r_wbEnhilo  <= 1'b0;
          end else begin
            r_wbWd     <= mem_wd_i;
            r_wbWreg   <= mem_wreg_i && !w_fault;
            r_wbWdata  <= mem_wdata_i;
            r_wbEnhilo <= mem_enhilo_i;
            r_wbHi     <= mem_hi_i;
            r_wbLo     <= mem_lo_i;
          end
        end
        BUSY: begin
          if (dbus_ack) begin
            r_dbusReq  <= 1'b0;
            r_wbWd     <= mem_wd_i;
            r_wbWreg   <= mem_wreg_i;
            r_wbWdata  <= w_isLoad ? w_loadData : mem_wdata_i;
            r_wbEnhilo <= mem_enhilo_i;
            r_wbHi     <= mem_hi_i;
            r_wbLo     <= mem_lo_i;
          end else begin
            r_wbWreg   <= 1'b0;
            r_wbEnhilo <= 1'b0;
          end
        end
        default: r_dbusReq <= 1'b0;
      endcase
    end
  end

  assign dbus_req   = r_dbusReq;
  assign dbus_we    = r_dbusWe;
  assign dbus_addr  = r_dbusAddr;
  assign dbus_be    = r_dbusBe;
  assign dbus_wdata = r_dbusWdata;
  assign wb_wd      = r_wbWd;
  assign wb_wreg    = r_wbWreg;
  assign wb_wdata   = r_wbWdata;
  assign wb_enhilo  = r_wbEnhilo;
  assign wb_hi      = r_wbHi;
  assign wb_lo      = r_wbLo;

`ifdef ADDR_EXC_EN
  logic              r_excAdel, r_excAdes;
  logic [ADDR_W-1:0] r_excBadvaddr;

  // Faults are only taken from IDLE; they never enter BUSY, so the pulse lasts one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_excAdel     <= 1'b0;
      r_excAdes     <= 1'b0;
      r_excBadvaddr <= '0;
    end else begin
      r_excAdel <= (r_state == IDLE) && w_fault && w_isLoad;
      r_excAdes <= (r_state == IDLE) && w_fault && w_isStore;
      if ((r_state == IDLE) && w_fault) r_excBadvaddr <= mem_addr_i;
    end
  end

  assign exc_adel     = r_excAdel;
  assign exc_ades     = r_excAdes;
  assign exc_badvaddr = r_excBadvaddr;
`else
  assign exc_adel     = 1'b0;
  assign exc_ades     = 1'b0;
  assign exc_badvaddr = '0;
`endif

endmodule
